// File: rtl/slave_demux.sv
// -----------------------------------------------------------------------------
// slave_demux
//   Slave-side router. One master port fans out to two slave ports. Each
//   request is steered by the top address bits. It is held on the chosen slave
//   until that slave acks, and the result is returned to the master as a
//   one-cycle response. A watchdog aborts requests that are never acked.
//
// Ports
//   clk, rst_n                    clock (posedge) / asynchronous active-low reset
//   i_master_req/addr/cmd/wdata   request from the master (cmd: 1=write, 0=read)
//   o_master_ack/rdata/err        one-cycle response; err = unmapped or timeout
//   o_slave_k_req/addr/cmd/wdata  request to slave k (k=1: sel==0, k=2: sel==1)
//   i_slave_k_ack/rdata           ack and read data from slave k
//
// Every output comes straight from a flop.
// -----------------------------------------------------------------------------
module slave_demux #(
  parameter int N               = 32,
  parameter int bits_addr_slave = 1,
  parameter int TIMEOUT         = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  // master port
  input  logic         i_master_req,
  input  logic [N-1:0] i_master_addr,
  input  logic         i_master_cmd,
  input  logic [N-1:0] i_master_wdata,
  output logic         o_master_ack,
  output logic [N-1:0] o_master_rdata,
  output logic         o_master_err,
  // slave 1 (select == 0)
  output logic         o_slave_1_req,
  output logic [N-1:0] o_slave_1_addr,
  output logic         o_slave_1_cmd,
  output logic [N-1:0] o_slave_1_wdata,
  input  logic         i_slave_1_ack,
  input  logic [N-1:0] i_slave_1_rdata,
  // slave 2 (select == 1)
  output logic         o_slave_2_req,
  output logic [N-1:0] o_slave_2_addr,
  output logic         o_slave_2_cmd,
  output logic [N-1:0] o_slave_2_wdata,
  input  logic         i_slave_2_ack,
  input  logic [N-1:0] i_slave_2_rdata
);

  // With the watchdog disabled, keep a 1-bit counter so the declaration stays
  // legal. It is never incremented in that case.
  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic         req;
    logic [N-1:0] addr;
    logic         cmd;
    logic [N-1:0] wdata;
  } slv_req_t;

  state_t                     r_state,     w_state_nxt;
  logic                       r_to_s2,     w_to_s2_nxt;
  logic [WD_W-1:0]            r_wd,        w_wd_nxt;
  slv_req_t                   r_s1,        w_s1_nxt;
  slv_req_t                   r_s2,        w_s2_nxt;
  logic                       r_ack,       w_ack_nxt;
  logic [N-1:0]               r_rdata,     w_rdata_nxt;
  logic                       r_err,       w_err_nxt;

  logic [bits_addr_slave-1:0] w_sel;
  slv_req_t                   w_req_in;
  logic                       w_slv_ack;
  logic [N-1:0]               w_slv_rdata;
  logic                       w_timeout;

  assign w_sel    = i_master_addr[N-1 -: bits_addr_slave];
  assign w_req_in = '{req: 1'b1, addr: i_master_addr, cmd: i_master_cmd,
                      wdata: i_master_wdata};

  // Only the latched target's ack counts. The other slave's ack is ignored.
  assign w_slv_ack   = r_to_s2 ? i_slave_2_ack   : i_slave_1_ack;
  assign w_slv_rdata = r_to_s2 ? i_slave_2_rdata : i_slave_1_rdata;

  // r_wd holds the number of completed BUSY cycles. The abort fires on the
  // edge that ends the TIMEOUT-th one.
  assign w_timeout = (TIMEOUT > 0) && (r_wd == WD_W'(TIMEOUT - 1));

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_to_s2_nxt = r_to_s2;
    w_wd_nxt    = '0;
    w_s1_nxt    = '0;
    w_s2_nxt    = '0;
    w_ack_nxt   = 1'b0;
    w_rdata_nxt = '0;
    w_err_nxt   = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (i_master_req) begin
          w_to_s2_nxt = (w_sel == bits_addr_slave'(1));
          if (w_sel == '0) begin
            w_s1_nxt    = w_req_in;
            w_state_nxt = ST_BUSY;
          end else if (w_sel == bits_addr_slave'(1)) begin
            w_s2_nxt    = w_req_in;
            w_state_nxt = ST_BUSY;
          end else begin
            // Unmapped select: answer with an error, no slave is touched.
            w_ack_nxt   = 1'b1;
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_RESP;
          end
        end
      end

      ST_BUSY: begin
        if (w_slv_ack) begin
          // An ack wins over a timeout that falls on the same edge.
          w_ack_nxt   = 1'b1;
          w_rdata_nxt = w_slv_rdata;
          w_state_nxt = ST_RESP;
        end else if (w_timeout) begin
          w_ack_nxt   = 1'b1;
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_RESP;
        end else begin
          // The non-selected slave register is already zero, so holding
          // both registers keeps only the target active.
          w_s1_nxt = r_s1;
          w_s2_nxt = r_s2;
          w_wd_nxt = (TIMEOUT > 0) ? r_wd + WD_W'(1) : '0;
        end
      end

      ST_RESP: begin
        // The master request is not sampled here. The master updates it
        // after seeing the ack.
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_to_s2 <= 1'b0;
      r_wd    <= '0;
      r_s1    <= '0;
      r_s2    <= '0;
      r_ack   <= 1'b0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_to_s2 <= w_to_s2_nxt;
      r_wd    <= w_wd_nxt;
      r_s1    <= w_s1_nxt;
      r_s2    <= w_s2_nxt;
      r_ack   <= w_ack_nxt;
      r_rdata <= w_rdata_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign o_master_ack    = r_ack;
  assign o_master_rdata  = r_rdata;
  assign o_master_err    = r_err;

  assign o_slave_1_req   = r_s1.req;
  assign o_slave_1_addr  = r_s1.addr;
  assign o_slave_1_cmd   = r_s1.cmd;
  assign o_slave_1_wdata = r_s1.wdata;

  assign o_slave_2_req   = r_s2.req;
  assign o_slave_2_addr  = r_s2.addr;
  assign o_slave_2_cmd   = r_s2.cmd;
  assign o_slave_2_wdata = r_s2.wdata;

endmodule

// File: tb/tb_slave_demux.sv
// -----------------------------------------------------------------------------
// tb_slave_demux
//   Main DUT:   N=32, one select bit, TIMEOUT=4.
//   Second DUT: two select bits (unmapped selects exist), watchdog disabled.
//
//   Expected slave/master activity for each request comes from a
//   transaction-level model:
//     - the selected slave is requested for min(lat+1, TIMEOUT) cycles;
//     - the master then gets one response cycle carrying either the slave
//       rdata (ack) or err with rdata=0 (timeout).
// -----------------------------------------------------------------------------
module tb_slave_demux;

  localparam int N          = 32;
  localparam int TB_TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // main DUT signals
  logic          m_req = 0, m_cmd = 0;
  logic [N-1:0]  m_addr = '0, m_wdata = '0;
  logic          m_ack, m_err;
  logic [N-1:0]  m_rdata;
  logic          s1_req, s1_cmd, s2_req, s2_cmd;
  logic [N-1:0]  s1_addr, s1_wdata, s2_addr, s2_wdata;
  logic          s1_ack = 0, s2_ack = 0;
  logic [N-1:0]  s1_rdata = '0, s2_rdata = '0;

  // second DUT signals
  logic          b_req = 0;
  logic [N-1:0]  b_addr = '0;
  logic          b_ack, b_err;
  logic [N-1:0]  b_rdata;
  logic          b_s1_req, b_s1_cmd, b_s2_req, b_s2_cmd;
  logic [N-1:0]  b_s1_addr, b_s1_wdata, b_s2_addr, b_s2_wdata;
  logic          b_s2_ack = 0;
  logic [N-1:0]  b_s2_rdata = '0;

  slave_demux #(.N(N), .bits_addr_slave(1), .TIMEOUT(TB_TIMEOUT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_master_req(m_req), .i_master_addr(m_addr), .i_master_cmd(m_cmd),
    .i_master_wdata(m_wdata),
    .o_master_ack(m_ack), .o_master_rdata(m_rdata), .o_master_err(m_err),
    .o_slave_1_req(s1_req), .o_slave_1_addr(s1_addr), .o_slave_1_cmd(s1_cmd),
    .o_slave_1_wdata(s1_wdata), .i_slave_1_ack(s1_ack), .i_slave_1_rdata(s1_rdata),
    .o_slave_2_req(s2_req), .o_slave_2_addr(s2_addr), .o_slave_2_cmd(s2_cmd),
    .o_slave_2_wdata(s2_wdata), .i_slave_2_ack(s2_ack), .i_slave_2_rdata(s2_rdata)
  );

  slave_demux #(.N(N), .bits_addr_slave(2), .TIMEOUT(0)) u_dut_wide (
    .clk(clk), .rst_n(rst_n),
    .i_master_req(b_req), .i_master_addr(b_addr), .i_master_cmd(1'b0),
    .i_master_wdata(32'h0),
    .o_master_ack(b_ack), .o_master_rdata(b_rdata), .o_master_err(b_err),
    .o_slave_1_req(b_s1_req), .o_slave_1_addr(b_s1_addr), .o_slave_1_cmd(b_s1_cmd),
    .o_slave_1_wdata(b_s1_wdata), .i_slave_1_ack(1'b0), .i_slave_1_rdata(32'h0),
    .o_slave_2_req(b_s2_req), .o_slave_2_addr(b_s2_addr), .o_slave_2_cmd(b_s2_cmd),
    .o_slave_2_wdata(b_s2_wdata), .i_slave_2_ack(b_s2_ack), .i_slave_2_rdata(b_s2_rdata)
  );

  typedef struct {
    logic          ack;
    logic [N-1:0]  rdata;
    logic          err;
    logic          r1;
    logic [N-1:0]  a1;
    logic          c1;
    logic [N-1:0]  w1;
    logic          r2;
    logic [N-1:0]  a2;
    logic          c2;
    logic [N-1:0]  w2;
  } outs_t;

  typedef struct {
    string         name;
    logic [N-1:0]  addr;
    logic          cmd;
    logic [N-1:0]  wdata;
    int            lat;    // ack in the (lat+1)-th request cycle
    logic [N-1:0]  rdata;
    logic          stray;  // random acks on the other slave and in IDLE/RESP
  } row_t;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [N-1:0] act,
                       input logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic outs_t zero_outs();
    outs_t e;
    e = '{default: '0};
    return e;
  endfunction

  task automatic chk_outs(input string tag, input outs_t e);
    check({tag, ".ack"},   32'(m_ack),   32'(e.ack));
    check({tag, ".rdata"}, m_rdata,      e.rdata);
    check({tag, ".err"},   32'(m_err),   32'(e.err));
    check({tag, ".s1req"}, 32'(s1_req),  32'(e.r1));
    check({tag, ".s1addr"}, s1_addr,     e.a1);
    check({tag, ".s1cmd"}, 32'(s1_cmd),  32'(e.c1));
    check({tag, ".s1wd"},  s1_wdata,     e.w1);
    check({tag, ".s2req"}, 32'(s2_req),  32'(e.r2));
    check({tag, ".s2addr"}, s2_addr,     e.a2);
    check({tag, ".s2cmd"}, 32'(s2_cmd),  32'(e.c2));
    check({tag, ".s2wd"},  s2_wdata,     e.w2);
  endtask

  task automatic stray_acks(input logic en);
    s1_ack   = en & 1'($urandom);
    s2_ack   = en & 1'($urandom);
    s1_rdata = $urandom;
    s2_rdata = $urandom;
  endtask

  // Entered at posedge+1 with the DUT idle; returns at posedge+1 with it idle.
  task automatic run_txn(input row_t r);
    outs_t e;
    logic  to2;
    logic  acked;
    int    n_req;
    to2   = r.addr[N-1];
    acked = (r.lat < TB_TIMEOUT);
    n_req = acked ? r.lat + 1 : TB_TIMEOUT;

    // IDLE cycle: the request is presented, stray acks must do nothing.
    m_req = 1'b1; m_addr = r.addr; m_cmd = r.cmd; m_wdata = r.wdata;
    stray_acks(r.stray);
    @(negedge clk);
    chk_outs({r.name, "/idle"}, zero_outs());
    @(posedge clk); #1;

    for (int c = 0; c < n_req; c++) begin
      // Master inputs change while busy; the latched request must persist.
      m_addr = $urandom; m_cmd = 1'($urandom); m_wdata = $urandom;
      stray_acks(r.stray);
      if (to2) begin
        s2_ack = (c == r.lat);
        if (c == r.lat) s2_rdata = r.rdata;
      end else begin
        s1_ack = (c == r.lat);
        if (c == r.lat) s1_rdata = r.rdata;
      end
      @(negedge clk);
      e = zero_outs();
      if (to2) begin
        e.r2 = 1'b1; e.a2 = r.addr; e.c2 = r.cmd; e.w2 = r.wdata;
      end else begin
        e.r1 = 1'b1; e.a1 = r.addr; e.c1 = r.cmd; e.w1 = r.wdata;
      end
      chk_outs({r.name, "/busy"}, e);
      @(posedge clk); #1;
    end

    // RESP cycle: master still holds req (ignored), acks ignored.
    stray_acks(r.stray);
    @(negedge clk);
    e = zero_outs();
    e.ack   = 1'b1;
    e.rdata = acked ? r.rdata : '0;
    e.err   = !acked;
    chk_outs({r.name, "/resp"}, e);
    @(posedge clk); #1;
    s1_ack = 1'b0; s2_ack = 1'b0;
  endtask

  row_t rows[6];
  row_t rr;

  initial begin
    rows[0] = '{"t1_rd_s1",    32'h0000_0010, 1'b0, 32'h0,         1,  32'hDEAD_BEEF, 1'b0};
    rows[1] = '{"t2_wr_s2",    32'h8000_0004, 1'b1, 32'h1234_5678, 0,  32'h0000_0000, 1'b0};
    rows[2] = '{"t3_timeout",  32'h0000_0020, 1'b0, 32'h0,         99, 32'h1111_1111, 1'b0};
    rows[3] = '{"t4_stray_s1", 32'h0000_0030, 1'b0, 32'h0,         2,  32'hCAFE_F00D, 1'b1};
    rows[4] = '{"t4_stray_s2", 32'h8000_0040, 1'b1, 32'hA5A5_5A5A, 2,  32'h0BAD_CAFE, 1'b1};
    rows[5] = '{"ack_at_tmo",  32'h7FFF_FFFC, 1'b1, 32'h0F0F_0F0F, 3,  32'h600D_600D, 1'b1};

    // Reset state.
    #2;
    chk_outs("reset", zero_outs());
    check("reset.b_ack", 32'(b_ack), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Table rows applied back-to-back (req held high into each IDLE cycle).
    foreach (rows[i]) run_txn(rows[i]);
    m_req = 1'b0;
    @(negedge clk);
    chk_outs("gap", zero_outs());
    @(posedge clk); #1;

    // Reset in the middle of a slave 2 transaction.
    m_req = 1'b1; m_addr = 32'h8000_0100; m_cmd = 1'b1; m_wdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rstmid.s2req_before", 32'(s2_req), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs("rstmid.async", zero_outs());
    m_req = 1'b0;
    s2_ack = 1'b1; s2_rdata = 32'hFFFF_0000;
    @(posedge clk); @(negedge clk);
    chk_outs("rstmid.held", zero_outs());
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      stray_acks(1'b1);
      @(negedge clk);
      chk_outs("rstmid.after", zero_outs());
    end
    @(posedge clk); #1;
    s1_ack = 1'b0; s2_ack = 1'b0;
    rr = '{"rstmid.new", 32'h8000_0200, 1'b0, 32'h0, 1, 32'h1357_9BDF, 1'b0};
    run_txn(rr);

    // Randomised transactions against the model in run_txn.
    for (int n = 0; n < 40; n++) begin
      rr.name  = "rnd";
      rr.addr  = $urandom;
      rr.cmd   = 1'($urandom);
      rr.wdata = $urandom;
      rr.lat   = int'($urandom_range(0, 6));
      rr.rdata = $urandom;
      rr.stray = 1'($urandom);
      run_txn(rr);
      if ($urandom_range(0, 2) == 0) begin
        m_req = 1'b0;
        stray_acks(1'b1);
        @(negedge clk);
        chk_outs("rnd/gap", zero_outs());
        @(posedge clk); #1;
        s1_ack = 1'b0; s2_ack = 1'b0;
      end
    end
    m_req = 1'b0;

    // Wide-select DUT: unmapped select 3 answers with err next cycle.
    b_req = 1'b1; b_addr = 32'hC000_0000;
    @(negedge clk);
    check("unm.idle_ack", 32'(b_ack), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("unm.ack",   32'(b_ack),    32'h1);
    check("unm.err",   32'(b_err),    32'h1);
    check("unm.rdata", b_rdata,       32'h0);
    check("unm.s1req", 32'(b_s1_req), 32'h0);
    check("unm.s2req", 32'(b_s2_req), 32'h0);
    @(posedge clk); #1;

    // Wide-select DUT: select 1 -> slave 2, watchdog off, long wait then ack.
    b_addr = 32'h4000_0008;
    @(negedge clk);
    check("nowd.idle_ack", 32'(b_ack), 32'h0);
    @(posedge clk); #1;
    for (int c = 0; c <= 20; c++) begin
      b_s2_ack   = (c == 20);
      b_s2_rdata = (c == 20) ? 32'h2468_ACE0 : 32'h0;
      @(negedge clk);
      check("nowd.s2req", 32'(b_s2_req), 32'h1);
      check("nowd.s2addr", b_s2_addr,    32'h4000_0008);
      check("nowd.s1req", 32'(b_s1_req), 32'h0);
      check("nowd.ack",   32'(b_ack),    32'h0);
      @(posedge clk); #1;
    end
    b_s2_ack = 1'b0; b_req = 1'b0;
    @(negedge clk);
    check("nowd.resp_ack", 32'(b_ack),    32'h1);
    check("nowd.resp_err", 32'(b_err),    32'h0);
    check("nowd.resp_rd",  b_rdata,       32'h2468_ACE0);
    check("nowd.resp_req", 32'(b_s2_req), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("nowd.back_idle", 32'(b_ack), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
